// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: shifts a BITS-wide word out on MOSI MSB-first while
// capturing BITS bits from MISO. SCLK idles low, and the slave samples on the
// rising edge. Every output is registered.
//
// Ports:
//   i_clk    system clock; everything runs on its rising edge
//   i_rst    synchronous active-high reset
//   i_start  start request, only looked at while o_busy is low
//   i_data   word to send, captured when a start is accepted
//   o_data   received word, updated when o_done pulses
//   o_busy   transaction in progress
//   o_done   one-cycle end-of-transaction pulse
//   o_sclk   SPI clock
//   o_mosi   serial data to the slave
//   i_miso   serial data from the slave
//   o_cs     chip select, active low
module spi_master_ctrl #(
  parameter int unsigned BITS    = 5,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [BITS-1:0] i_data,
  output logic [BITS-1:0] o_data,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_sclk,
  output logic            o_mosi,
  input  logic            i_miso,
  output logic            o_cs
);

  localparam int unsigned PW = $clog2(CLK_DIV) + 1;
  localparam int unsigned BW = $clog2(BITS) + 1;

  typedef enum logic [1:0] {StIdle, StLead, StHigh, StLow} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ph_q, ph_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [BITS-1:0] tx_q, tx_d;
  logic [BITS-1:0] rx_q, rx_d;
  logic [BITS-1:0] data_q, data_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            cs_q, cs_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            ph_last;
  logic [BITS-1:0] tx_shl;
  logic [BITS-1:0] rx_in;
  logic [BW-1:0]   bit_inc;

  assign ph_last = (ph_q == PW'(CLK_DIV - 1));
  assign tx_shl  = tx_q << 1;
  // Shift-left form keeps BITS=1 legal (no [BITS-2:0] slice).
  assign rx_in   = (rx_q << 1) | BITS'(i_miso);
  assign bit_inc = bit_q + BW'(1);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          tx_d    = i_data;
          mosi_d  = i_data[BITS-1];
          rx_d    = '0;
          ph_d    = '0;
          bit_d   = '0;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = StLead;
        end
      end

      // CS setup time; the first MISO sample goes with the first SCLK rise.
      StLead: begin
        if (ph_last) begin
          rx_d    = rx_in;
          sclk_d  = 1'b1;
          ph_d    = '0;
          state_d = StHigh;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end

      StHigh: begin
        if (ph_last) begin
          sclk_d  = 1'b0;
          ph_d    = '0;
          bit_d   = bit_inc;
          // Next MOSI bit goes out with the falling edge.
          if (bit_inc < BW'(BITS)) begin
            tx_d   = tx_shl;
            mosi_d = tx_shl[BITS-1];
          end
          state_d = StLow;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end

      // The final low phase doubles as CS hold time.
      StLow: begin
        if (ph_last) begin
          ph_d = '0;
          if (bit_q == BW'(BITS)) begin
            cs_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            mosi_d  = 1'b0;
            data_d  = rx_q;
            state_d = StIdle;
          end else begin
            rx_d    = rx_in;
            sclk_d  = 1'b1;
            state_d = StHigh;
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      ph_q    <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_data = data_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_sclk = sclk_q;
  assign o_mosi = mosi_q;
  assign o_cs   = cs_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: default instance (BITS=5, CLK_DIV=2) with a
// selectable MISO source (loopback, tied 1, tied 0, mode-0 5-bit delay slave),
// plus a BITS=1, CLK_DIV=1 loopback instance.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [4:0] data;
  logic [4:0] rdata;
  logic       busy, done, sclk, mosi, cs, miso;
  logic [1:0] miso_sel;

  // Downstream unit model: captures MOSI on SCLK rise, shifts on SCLK fall,
  // so MISO echoes MOSI five bits late.
  logic [4:0] slv_sr;
  logic       slv_cap;
  logic       slv_clr;
  always @(posedge sclk) slv_cap <= mosi;
  always @(negedge sclk or posedge slv_clr)
    if (slv_clr) slv_sr <= '0;
    else         slv_sr <= {slv_sr[3:0], slv_cap};

  always_comb begin
    miso = 1'b0;
    case (miso_sel)
      2'd0:    miso = mosi;
      2'd1:    miso = 1'b1;
      2'd2:    miso = 1'b0;
      default: miso = slv_sr[4];
    endcase
  end

  spi_master_ctrl #(.BITS(5), .CLK_DIV(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_data(data), .o_data(rdata),
    .o_busy(busy), .o_done(done), .o_sclk(sclk), .o_mosi(mosi), .i_miso(miso),
    .o_cs(cs)
  );

  logic       start1;
  logic [0:0] data1, rdata1;
  logic       busy1, done1, sclk1, mosi1, cs1;

  spi_master_ctrl #(.BITS(1), .CLK_DIV(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_data(data1), .o_data(rdata1),
    .o_busy(busy1), .o_done(done1), .o_sclk(sclk1), .o_mosi(mosi1), .i_miso(mosi1),
    .o_cs(cs1)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [4:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer on the default instance and checks framing, MOSI
  // sequence and the received word against the scoreboard head.
  // launch=0: start was already accepted (held through the previous o_done).
  // hold=1: keep i_start high so the next word follows directly.
  // poke>=0: pulse a stray start with a different word at that cycle.
  task automatic xfer(input string tag, input logic [4:0] d, input logic launch,
                      input logic hold, input logic [4:0] next_d, input int poke);
    int         cs_low, rises, unstable;
    logic [4:0] seq;
    logic       prev_sclk, prev_mosi, got;
    seq = '0; rises = 0; unstable = 0; got = 1'b0;
    if (launch) begin
      start = 1'b1;
      data  = d;
      step();
    end
    if (!hold) start = 1'b0;
    cs_low    = (cs === 1'b0) ? 1 : 0;
    prev_sclk = sclk;
    prev_mosi = mosi;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sclk === 1'b1 && prev_sclk === 1'b0) begin
        rises++;
        seq = {seq[3:0], mosi};
        if (mosi !== prev_mosi) unstable++;
      end
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (cs === 1'b0) cs_low++;
      prev_sclk = sclk;
      prev_mosi = mosi;
      if (i == poke) begin
        start = 1'b1;
        data  = ~d;
      end else if (!hold) begin
        start = 1'b0;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_cs_low"}, cs_low, 32'd22);
      check({tag, "_rises"}, rises, 32'd5);
      check({tag, "_mosi_seq"}, 32'(seq), 32'(d));
      check({tag, "_mosi_stable"}, unstable, 32'd0);
      check({tag, "_cs_at_done"}, 32'(cs), 32'd1);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      if (sb.size() > 0) check({tag, "_rx"}, 32'(rdata), 32'(sb.pop_front()));
      if (hold) begin
        data = next_d;
        step();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_cs_refall"}, 32'(cs), 32'd0);
      end else begin
        step();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_cs_idle"}, 32'(cs), 32'd1);
        check({tag, "_mosi_idle"}, 32'(mosi), 32'd0);
      end
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    int dcount, c1_low, c1_high;
    logic got1;
    rst = 1'b1; start = 1'b0; data = '0; miso_sel = 2'd0; slv_clr = 1'b0;
    start1 = 1'b0; data1 = '0;
    repeat (3) step();
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(rdata), 32'd0);
    rst = 1'b0;
    step();

    // Loopback
    sb.push_back(5'b10110);
    xfer("loop", 5'b10110, 1'b1, 1'b0, 5'b0, -1);

    // MISO tied high then low
    miso_sel = 2'd1;
    sb.push_back(5'b11111);
    xfer("ones", 5'b00000, 1'b1, 1'b0, 5'b0, -1);
    miso_sel = 2'd2;
    sb.push_back(5'b00000);
    xfer("zeros", 5'b00000, 1'b1, 1'b0, 5'b0, -1);

    // Back-to-back through the delay slave: word 2 receives word 1
    miso_sel = 2'd3;
    slv_clr = 1'b1;
    #1 slv_clr = 1'b0;
    sb.push_back(5'b00000);
    sb.push_back(5'b11001);
    xfer("b2b1", 5'b11001, 1'b1, 1'b1, 5'b00111, -1);
    xfer("b2b2", 5'b00111, 1'b0, 1'b0, 5'b0, -1);

    // Stray start mid-transfer is ignored
    miso_sel = 2'd0;
    sb.push_back(5'b10110);
    xfer("ign", 5'b10110, 1'b1, 1'b0, 5'b0, 5);

    // Reset mid-transfer
    start = 1'b1; data = 5'b10011;
    step();
    start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    check("abort_cs", 32'(cs), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data", 32'(rdata), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done === 1'b1) dcount++;
    end
    check("abort_no_done", dcount, 32'd0);
    sb.push_back(5'b01101);
    xfer("post_rst", 5'b01101, 1'b1, 1'b0, 5'b0, -1);

    // BITS=1, CLK_DIV=1 loopback
    start1 = 1'b1; data1 = 1'b1;
    step();
    start1 = 1'b0;
    c1_low  = (cs1 === 1'b0) ? 1 : 0;
    c1_high = (sclk1 === 1'b1) ? 1 : 0;
    got1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done1 === 1'b1) begin
        got1 = 1'b1;
        break;
      end
      if (cs1 === 1'b0) c1_low++;
      if (sclk1 === 1'b1) c1_high++;
    end
    check("b1_done_seen", 32'(got1), 32'd1);
    check("b1_cs_low", c1_low, 32'd3);
    check("b1_sclk_high", c1_high, 32'd1);
    check("b1_rx", 32'(rdata1), 32'd1);
    check("b1_busy", 32'(busy1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
